// File: rtl/mma_access_arbiter.sv
// Access arbiter for the MMA ICB port. It grants one channel at a time, by fixed or
// round-robin priority, and forces a release when a grant is held too long.
module mma_access_arbiter #(
  parameter int NUM_CH   = 5,
  parameter int ARB_MODE = 1,
  parameter int HOLD_MAX = 1024,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] done,
  input  logic              err_clr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  icb_sel,
  output logic              busy,
  output logic              timeout_err,
  output logic [SEL_W-1:0]  timeout_ch,
  output logic [1:0]        dbg_state
);

  // Handshake: req is a level held by the channel; grant is the registered one-hot
  // answer; done is a one-cycle pulse from the granted channel only (others ignored).

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = HC_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  state_t            state, state_d;
  logic [NUM_CH-1:0] grant_d;
  logic [SEL_W-1:0]  sel_d, tch_d, rr_ptr, rr_d;
  logic              busy_d, err_d;
  logic [HC_W-1:0]   hold_cnt, cnt_d;

  logic [NUM_CH-1:0]   eligible, rot;
  logic [2*NUM_CH-1:0] dbl;
  logic [SEL_W-1:0]    base, off, win_idx, rr_nxt;
  logic [SEL_W:0]      sum, nxt_sum;
  logic                win_found, done_cur, hold_hit;

  assign eligible = req & ch_mask;
  assign base     = (ARB_MODE == 1) ? rr_ptr : '0;
  // Rotate the eligible set so the search always starts at bit 0.
  assign dbl      = {eligible, eligible} >> base;
  assign rot      = dbl[NUM_CH-1:0];

  always_comb begin
    win_found = 1'b0;
    off       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!win_found && rot[i]) begin
        win_found = 1'b1;
        off       = SEL_W'(i);
      end
    end
  end

  assign sum     = {1'b0, base} + {1'b0, off};
  assign win_idx = (sum >= (SEL_W+1)'(NUM_CH)) ? SEL_W'(sum - (SEL_W+1)'(NUM_CH))
                                               : SEL_W'(sum);
  assign nxt_sum = {1'b0, icb_sel} + (SEL_W+1)'(1);
  assign rr_nxt  = (nxt_sum >= (SEL_W+1)'(NUM_CH)) ? '0 : SEL_W'(nxt_sum);

  assign done_cur = |(done & grant);
  assign hold_hit = (HOLD_MAX > 0) && (hold_cnt == HOLD_LIM);

  always_comb begin
    state_d = state;
    grant_d = grant;
    sel_d   = icb_sel;
    cnt_d   = hold_cnt;
    rr_d    = rr_ptr;
    err_d   = timeout_err;
    tch_d   = timeout_ch;
    if (err_clr) err_d = 1'b0;
    case (state)
      // RELEASE arbitrates too, so back-to-back grants have exactly one dead cycle.
      IDLE, RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
        if (arb_en && win_found) begin
          state_d = GRANT;
          grant_d = NUM_CH'(1) << win_idx;
          sel_d   = win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = hold_cnt + HC_W'(1);
        if (done_cur) begin
          state_d = RELEASE;
          grant_d = '0;
          rr_d    = rr_nxt;
        end else if (hold_hit) begin
          state_d = RELEASE;
          grant_d = '0;
          rr_d    = rr_nxt;
          err_d   = 1'b1;
          tch_d   = icb_sel;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      icb_sel     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      timeout_ch  <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      icb_sel     <= sel_d;
      busy        <= busy_d;
      timeout_err <= err_d;
      timeout_ch  <= tch_d;
      rr_ptr      <= rr_d;
      hold_cnt    <= cnt_d;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mma_access_arbiter.sv
// Directed bench: a round-robin instance with an 8-cycle hold limit and a
// fixed-priority instance, each checked against hand-computed expectations.
module tb_mma_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       rr_rst, rr_en, rr_clr;
  logic [4:0] rr_mask, rr_req, rr_done, rr_grant;
  logic [2:0] rr_sel, rr_tch;
  logic       rr_busy, rr_err;
  logic [1:0] rr_st;

  logic       fx_rst, fx_en, fx_clr;
  logic [4:0] fx_mask, fx_req, fx_done, fx_grant;
  logic [2:0] fx_sel, fx_tch;
  logic       fx_busy, fx_err;
  logic [1:0] fx_st;

  mma_access_arbiter #(.NUM_CH(5), .ARB_MODE(1), .HOLD_MAX(8)) u_rr (
    .clk(clk), .rst(rr_rst), .arb_en(rr_en), .ch_mask(rr_mask), .req(rr_req),
    .done(rr_done), .err_clr(rr_clr), .grant(rr_grant), .icb_sel(rr_sel),
    .busy(rr_busy), .timeout_err(rr_err), .timeout_ch(rr_tch), .dbg_state(rr_st)
  );

  mma_access_arbiter #(.NUM_CH(5), .ARB_MODE(0), .HOLD_MAX(8)) u_fx (
    .clk(clk), .rst(fx_rst), .arb_en(fx_en), .ch_mask(fx_mask), .req(fx_req),
    .done(fx_done), .err_clr(fx_clr), .grant(fx_grant), .icb_sel(fx_sel),
    .busy(fx_busy), .timeout_err(fx_err), .timeout_ch(fx_tch), .dbg_state(fx_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rr_order[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rr_rst = 1; rr_en = 0; rr_clr = 0; rr_mask = 0; rr_req = 0; rr_done = 0;
    fx_rst = 1; fx_en = 0; fx_clr = 0; fx_mask = 0; fx_req = 0; fx_done = 0;
    step(); step();
    check("rst_grant", 32'(rr_grant), 0);
    check("rst_busy", 32'(rr_busy), 0);
    check("rst_state", 32'(rr_st), 0);
    rr_rst = 0; fx_rst = 0;

    // Round-robin rotation with a one-cycle gap between grants.
    rr_req = 5'b11111; rr_mask = 5'b11111; rr_en = 1;
    step();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_grant_%0d", k), 32'(rr_grant), 32'(1) << rr_order[k]);
      check($sformatf("rr_sel_%0d", k), 32'(rr_sel), 32'(rr_order[k]));
      step(); step();
      rr_done = 5'(32'(1) << rr_order[k]);
      step();
      rr_done = 0;
      check($sformatf("rr_gap_%0d", k), 32'(rr_grant), 0);
      check($sformatf("rr_gap_busy_%0d", k), 32'(rr_busy), 1);
      if (k == 5) rr_req = 5'b01000;
      step();
    end

    // Timeout: ch3 held without done for the full 8-cycle limit.
    check("to_grant0", 32'(rr_grant), 32'h08);
    repeat (7) step();
    check("to_grant7", 32'(rr_grant), 32'h08);
    check("to_err_early", 32'(rr_err), 0);
    step();
    check("to_drop", 32'(rr_grant), 0);
    check("to_err", 32'(rr_err), 1);
    check("to_ch", 32'(rr_tch), 3);
    check("to_sel_hold", 32'(rr_sel), 3);
    rr_req = 0; rr_clr = 1;
    step();
    rr_clr = 0;
    check("err_clr", 32'(rr_err), 0);

    // done on the 8th grant cycle wins over the timeout.
    rr_req = 5'b00100;
    step();
    check("dl_grant", 32'(rr_grant), 32'h04);
    repeat (7) step();
    rr_done = 5'b00100;
    step();
    rr_done = 0; rr_req = 0;
    check("dl_drop", 32'(rr_grant), 0);
    check("dl_no_err", 32'(rr_err), 0);
    step();

    // Reset mid-grant, then ch0 first after reset.
    rr_req = 5'b00100;
    step();
    check("mr_grant", 32'(rr_grant), 32'h04);
    rr_rst = 1; rr_req = 5'b11111;
    step();
    check("mr_grant_rst", 32'(rr_grant), 0);
    check("mr_sel_rst", 32'(rr_sel), 0);
    check("mr_busy_rst", 32'(rr_busy), 0);
    check("mr_tch_rst", 32'(rr_tch), 0);
    rr_rst = 0;
    step();
    check("mr_first", 32'(rr_grant), 32'h01);

    // Fixed priority instance.
    fx_req = 5'b10110; fx_mask = 5'b11111; fx_en = 1;
    step();
    check("fx_grant1", 32'(fx_grant), 32'h02);
    check("fx_sel1", 32'(fx_sel), 1);
    fx_mask = 0; fx_en = 0;
    step();
    check("fx_hold", 32'(fx_grant), 32'h02);
    fx_mask = 5'b11111; fx_en = 1; fx_done = 5'b00010;
    step();
    fx_done = 0;
    check("fx_rel", 32'(fx_grant), 0);
    step();
    check("fx_again1", 32'(fx_grant), 32'h02);
    fx_mask = 5'b11101; fx_done = 5'b00010;
    step();
    fx_done = 0;
    step();
    check("fx_mask_ch2", 32'(fx_grant), 32'h04);
    check("fx_sel2", 32'(fx_sel), 2);
    fx_done = 5'b00100;
    step();
    fx_done = 0; fx_req = 5'b00001; fx_mask = 5'b11111;
    check("fx_sel_rel", 32'(fx_sel), 2);
    step();
    check("fx_ch0", 32'(fx_grant), 32'h01);
    fx_done = 5'b00100;
    step();
    check("fx_ignore_done", 32'(fx_grant), 32'h01);
    fx_done = 5'b00001;
    step();
    fx_done = 0; fx_en = 0;
    check("fx_rel0", 32'(fx_grant), 0);
    step();
    check("fx_en_off", 32'(fx_grant), 0);
    step();
    check("fx_idle_busy", 32'(fx_busy), 0);
    check("fx_idle_grant", 32'(fx_grant), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mma_access_arbiter.md
MMA_ACCESS_ARBITER -- requirements
Module: mma_access_arbiter

Interface
REQ-001 Parameter NUM_CH, default 5, number of requesting channels (IA, weight, bias, quant, OA); legal range 2..16.
REQ-002 Parameter ARB_MODE, default 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 Parameter HOLD_MAX, default 1024, maximum grant cycles before forced release; 0 disables the timeout.
REQ-004 Parameter SEL_W, default $clog2(NUM_CH), width of the encoded select.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 arb_en  in  1  when high, new grants are allowed.
REQ-008 ch_mask  in  NUM_CH  per-channel enable; a masked channel is never granted.
REQ-009 req  in  NUM_CH  level access requests, one bit per channel.
REQ-010 done  in  NUM_CH  single-cycle completion pulses, one bit per channel.
REQ-011 err_clr  in  1  clears the sticky timeout error.
REQ-012 grant  out  NUM_CH  registered one-hot grant.
REQ-013 icb_sel  out  SEL_W  registered index of the current or last granted channel (ICB mux select).
REQ-014 busy  out  1  high while in GRANT or RELEASE.
REQ-015 timeout_err  out  1  sticky flag: a grant was force-released.
REQ-016 timeout_ch  out  SEL_W  index of the channel that last timed out.

Function
REQ-017 FSM states SHALL be IDLE, GRANT and RELEASE; all outputs SHALL be registered.
REQ-018 Eligible set = req & ch_mask; in IDLE with arb_en=1 and a non-empty eligible set, the arbiter SHALL enter GRANT and assert exactly one grant bit on the next cycle, with icb_sel updated in the same cycle.
REQ-019 Latency: req sampled at cycle t in IDLE -> grant high at t+1.
REQ-020 ARB_MODE=0: winner = lowest eligible index.
REQ-021 ARB_MODE=1: search starts at rr_ptr and wraps modulo NUM_CH; on each release rr_ptr = (granted index + 1) mod NUM_CH, so index NUM_CH-1 wraps to 0.
REQ-022 In GRANT, grant and icb_sel SHALL hold even if req, ch_mask or arb_en change.
REQ-023 done bits for non-granted channels SHALL be ignored.
REQ-024 done[cur] at cycle t in GRANT -> RELEASE at t+1 with grant all-zero; IDLE at t+2; the earliest next grant is t+2 (one guaranteed dead cycle for ICB switchover).
REQ-025 icb_sel SHALL keep the last granted index through RELEASE and IDLE.
REQ-026 Hold counter: cleared on entry to GRANT, incremented every GRANT cycle; if HOLD_MAX>0 and the count reaches HOLD_MAX-1 without done[cur], the arbiter SHALL go to RELEASE next cycle, set timeout_err=1 and load timeout_ch=cur.
REQ-027 If done[cur] and the timeout condition occur in the same cycle, done wins; no error is flagged.
REQ-028 err_clr clears timeout_err; if a new timeout occurs in the same cycle, set wins.
REQ-029 A timed-out release SHALL update rr_ptr exactly as a normal release.
REQ-030 arb_en=0 SHALL block new grants only; an active grant completes normally.
REQ-031 The arbiter SHALL never assert more than one grant bit, and never assert grant in the cycle immediately after a release.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, grant=0, icb_sel=0, busy=0, timeout_err=0, timeout_ch=0, rr_ptr=0 and hold counter=0, including mid-grant; the first grant is possible in the cycle after rst deasserts.

Verification
REQ-033 RR, NUM_CH=5, req=5'b11111 constant, done pulsed 2 cycles after each grant -> grant order ch0,1,2,3,4,0, with a one-cycle all-zero gap between grants.
REQ-034 Fixed mode, req=5'b10110 -> grant ch1; after done -> ch1 again while req[1] stays high; ch_mask=5'b11101 -> ch2.
REQ-035 HOLD_MAX=8, ch3 granted, no done -> grant drops after 8 cycles, timeout_err=1, timeout_ch=3; err_clr -> timeout_err=0 on the next cycle.
REQ-036 done[cur] on the 8th grant cycle with HOLD_MAX=8 -> normal release, timeout_err stays 0; done[2] while ch0 is granted -> ignored.
REQ-037 rst asserted mid-grant -> all outputs at reset values on the next cycle; req held -> grant ch0 one cycle after rst deasserts.
